// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the main-memory port arbiter.
// Holds the FSM/owner encodings and the streak counter sizing helper.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   typedef enum logic [1:0] {
      NONE   = 2'd0,
      IFETCH = 2'd1,
      DATA   = 2'd2
   } arb_owner_t;

   localparam int DEFAULT_ADDR_W      = 32;
   localparam int DEFAULT_LINE_W      = 128;
   localparam int DEFAULT_MAX_DSTREAK = 4;

   // Counter must be able to hold the value max_streak itself.
   function automatic int streak_cnt_w(input int max_streak);
      int w;
      w = $clog2(max_streak + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and memory handshakes of the shared memory port.
// master = arbiter view, slave = requesters plus memory model view.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 128
);

   logic              i_req_valid;
   logic [ADDR_W-1:0] i_req_addr;
   logic              i_req_ready;
   logic              i_resp_valid;
   logic [LINE_W-1:0] i_resp_data;

   logic              d_req_valid;
   logic              d_req_write;
   logic [ADDR_W-1:0] d_req_addr;
   logic [LINE_W-1:0] d_req_wdata;
   logic              d_req_ready;
   logic              d_resp_valid;
   logic [LINE_W-1:0] d_resp_data;

   logic              mem_req_valid;
   logic              mem_req_ready;
   logic              mem_req_write;
   logic [ADDR_W-1:0] mem_req_addr;
   logic [LINE_W-1:0] mem_req_wdata;
   logic              mem_resp_valid;
   logic [LINE_W-1:0] mem_resp_data;

   modport master (
      input  i_req_valid, i_req_addr,
      output i_req_ready, i_resp_valid, i_resp_data,
      input  d_req_valid, d_req_write, d_req_addr, d_req_wdata,
      output d_req_ready, d_resp_valid, d_resp_data,
      output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
      input  mem_req_ready, mem_resp_valid, mem_resp_data
   );

   modport slave (
      output i_req_valid, i_req_addr,
      input  i_req_ready, i_resp_valid, i_resp_data,
      output d_req_valid, d_req_write, d_req_addr, d_req_wdata,
      input  d_req_ready, d_resp_valid, d_resp_data,
      input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
      output mem_req_ready, mem_resp_valid, mem_resp_data
   );

endinterface

// File: rtl/mem_arb_priority.sv
// Data-first winner selection with a saturating data-streak counter that
// guarantees fetch a grant after MAX_DSTREAK back-to-back data grants.
module mem_arb_priority
   import mem_arb_pkg::*;
#(
   parameter int MAX_DSTREAK = DEFAULT_MAX_DSTREAK
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_valid,
   input  logic       d_valid,
   input  logic       i_accept,
   input  logic       d_accept,
   output arb_owner_t winner
);

   localparam int               CNT_W      = streak_cnt_w(MAX_DSTREAK);
   localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_DSTREAK);

   logic [CNT_W-1:0] dstreak_reg;
   logic [CNT_W-1:0] dstreak_next;
   logic             fetch_starved;

   // Idle cycles leave the streak alone; only an actual fetch grant resets it.
   always_comb begin
      dstreak_next = dstreak_reg;
      if (i_accept) begin
         dstreak_next = '0;
      end else if (d_accept && (dstreak_reg != STREAK_MAX)) begin
         dstreak_next = dstreak_reg + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dstreak_reg <= '0;
      end else begin
         dstreak_reg <= dstreak_next;
      end
   end

   assign fetch_starved = i_valid && (dstreak_reg == STREAK_MAX);

   always_comb begin
      winner = NONE;
      if (d_valid && !fetch_starved) begin
         winner = DATA;
      end else if (i_valid) begin
         winner = IFETCH;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between fetch refill and data traffic,
// one outstanding transaction at a time, response routed back to the owner.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = DEFAULT_ADDR_W,
   parameter int LINE_W      = DEFAULT_LINE_W,
   parameter int MAX_DSTREAK = DEFAULT_MAX_DSTREAK
) (
   input  logic                clk,
   input  logic                reset,
   mem_port_arbiter_if.master  bus,
   output logic                busy
);

   arb_state_t        state_reg;
   arb_state_t        state_next;
   arb_owner_t        owner_reg;
   arb_owner_t        owner_next;
   arb_owner_t        winner;

   logic [LINE_W-1:0] i_data_reg;
   logic [LINE_W-1:0] i_data_next;
   logic [LINE_W-1:0] d_data_reg;
   logic [LINE_W-1:0] d_data_next;

   logic              granting;
   logic              i_ready;
   logic              d_ready;
   logic              i_accept;
   logic              d_accept;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [LINE_W-1:0] req_wdata;

   mem_arb_priority #(
      .MAX_DSTREAK (MAX_DSTREAK)
   ) u_priority (
      .clk      (clk),
      .reset    (reset),
      .i_valid  (bus.i_req_valid),
      .d_valid  (bus.d_req_valid),
      .i_accept (i_accept),
      .d_accept (d_accept),
      .winner   (winner)
   );

   // Grants only exist in IDLE; reset masks them so outputs are quiet while it is held.
   assign granting = (state_reg == IDLE) && !reset && (winner != NONE);
   assign i_ready  = granting && (winner == IFETCH) && bus.mem_req_ready;
   assign d_ready  = granting && (winner == DATA) && bus.mem_req_ready;
   assign i_accept = i_ready && bus.i_req_valid;
   assign d_accept = d_ready && bus.d_req_valid;

   always_comb begin
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      if (granting) begin
         if (winner == DATA) begin
            req_write = bus.d_req_write;
            req_addr  = bus.d_req_addr;
            req_wdata = bus.d_req_wdata;
         end else begin
            req_addr  = bus.i_req_addr;
         end
      end
   end

   assign bus.mem_req_valid = granting;
   assign bus.mem_req_write = req_write;
   assign bus.mem_req_addr  = req_addr;
   assign bus.mem_req_wdata = req_wdata;
   assign bus.i_req_ready   = i_ready;
   assign bus.d_req_ready   = d_ready;

   always_comb begin
      state_next  = state_reg;
      owner_next  = owner_reg;
      i_data_next = i_data_reg;
      d_data_next = d_data_reg;
      case (state_reg)
         IDLE: begin
            if (d_accept) begin
               state_next = WAIT;
               owner_next = DATA;
            end else if (i_accept) begin
               state_next = WAIT;
               owner_next = IFETCH;
            end
         end
         WAIT: begin
            // Separate capture registers let each port hold its own last line.
            if (bus.mem_resp_valid) begin
               state_next = RESP;
               if (owner_reg == DATA) begin
                  d_data_next = bus.mem_resp_data;
               end else begin
                  i_data_next = bus.mem_resp_data;
               end
            end
         end
         RESP: begin
            state_next = IDLE;
            owner_next = NONE;
         end
         default: begin
            state_next = IDLE;
            owner_next = NONE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= IDLE;
         owner_reg  <= NONE;
         i_data_reg <= '0;
         d_data_reg <= '0;
      end else begin
         state_reg  <= state_next;
         owner_reg  <= owner_next;
         i_data_reg <= i_data_next;
         d_data_reg <= d_data_next;
      end
   end

   assign bus.i_resp_valid = (state_reg == RESP) && (owner_reg == IFETCH) && !reset;
   assign bus.d_resp_valid = (state_reg == RESP) && (owner_reg == DATA) && !reset;
   assign bus.i_resp_data  = i_data_reg;
   assign bus.d_resp_data  = d_data_reg;
   assign busy             = (state_reg != IDLE) && !reset;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: transaction-level model of the shared port checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int ADDR_W = 32;
   localparam int LINE_W = 128;
   localparam int MAXS   = 4;

   logic clk = 1'b0;
   logic reset;
   logic busy;

   mem_port_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

   mem_port_arbiter #(
      .ADDR_W      (ADDR_W),
      .LINE_W      (LINE_W),
      .MAX_DSTREAK (MAXS)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // environment knobs
   int                ready_mode  = 1;
   int                lat_fix     = 3;
   bit                data_fix_en = 1'b0;
   logic [LINE_W-1:0] data_fix    = '0;
   bit                spur_en     = 1'b0;
   bit                force_resp  = 1'b0;
   bit                rand_reqs   = 1'b0;
   bit                sticky      = 1'b0;

   // transaction-level model
   bit                m_busy, m_have, m_owner_d, m_write, m_d_known;
   int                m_streak, m_cnt;
   logic [LINE_W-1:0] m_mem_data, m_i_last, m_d_last;

   // observations of the DUT for the directed scenarios
   int                i_acc_cyc, d_acc_cyc, i_resp_cyc, d_resp_cyc;
   int                i_resp_cnt, d_resp_cnt, busy_cnt, busy_first;
   logic [LINE_W-1:0] i_resp_seen;
   bit                cap_write;
   logic [ADDR_W-1:0] cap_addr;
   logic [LINE_W-1:0] cap_wdata;
   bit                acc_i, acc_d;
   bit                glog[$];

   function automatic logic [LINE_W-1:0] rand_line();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic tally(input bit ok, input string name, input string got, input string want);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%s want=%s", name, cyc, got, want);
      end
   endtask

   task automatic chk1(input string n, input logic a, input logic e);
      tally(a === e, n, $sformatf("%0b", a), $sformatf("%0b", e));
   endtask

   task automatic chka(input string n, input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] e);
      tally(a === e, n, $sformatf("%0h", a), $sformatf("%0h", e));
   endtask

   task automatic chkw(input string n, input logic [LINE_W-1:0] a, input logic [LINE_W-1:0] e);
      tally(a === e, n, $sformatf("%0h", a), $sformatf("%0h", e));
   endtask

   task automatic chki(input string n, input int a, input int e);
      tally(a == e, n, $sformatf("%0d", a), $sformatf("%0d", e));
   endtask

   task automatic reset_obs();
      i_acc_cyc  = -1;
      d_acc_cyc  = -1;
      i_resp_cyc = -1;
      d_resp_cyc = -1;
      i_resp_cnt = 0;
      d_resp_cnt = 0;
      busy_cnt   = 0;
      busy_first = -1;
      cap_write  = 1'b0;
      cap_addr   = '0;
      cap_wdata  = '0;
   endtask

   task automatic model_clear();
      m_busy    = 1'b0;
      m_have    = 1'b0;
      m_owner_d = 1'b0;
      m_write   = 1'b0;
      m_d_known = 1'b1;
      m_streak  = 0;
      m_cnt     = 0;
      m_i_last  = '0;
      m_d_last  = '0;
   endtask

   // One clock cycle: drive memory, compare against the model, advance the model.
   task automatic step();
      logic              iv, dv, dw, mrv;
      logic              e_ir, e_dr, e_mv, e_mw, e_iv, e_dv, e_busy, d_wins;
      logic [ADDR_W-1:0] e_ma;
      logic [LINE_W-1:0] e_md, mrd;
      int                lat;

      if (ready_mode < 0) bus.mem_req_ready = ($urandom_range(0, 3) != 0);
      else                bus.mem_req_ready = (ready_mode != 0);
      mrv = 1'b0;
      mrd = rand_line();
      if (m_busy && !m_have && m_cnt == 0) begin
         mrv = 1'b1;
         mrd = m_mem_data;
      end else if (!m_busy || m_have) begin
         if (force_resp || (spur_en && $urandom_range(0, 7) == 0)) mrv = 1'b1;
      end
      bus.mem_resp_valid = mrv;
      bus.mem_resp_data  = mrd;
      #1;

      iv = bus.i_req_valid;
      dv = bus.d_req_valid;
      dw = bus.d_req_write;
      e_ir = 0; e_dr = 0; e_mv = 0; e_mw = 0; e_iv = 0; e_dv = 0; e_busy = 0;
      e_ma = '0; e_md = '0;
      if (!reset) begin
         if (!m_busy) begin
            d_wins = dv && !(iv && m_streak == MAXS);
            if (d_wins) begin
               e_mv = 1; e_mw = dw; e_ma = bus.d_req_addr; e_md = bus.d_req_wdata;
               e_dr = bus.mem_req_ready;
            end else if (iv) begin
               e_mv = 1; e_ma = bus.i_req_addr;
               e_ir = bus.mem_req_ready;
            end
         end else begin
            e_busy = 1;
            if (m_have) begin
               if (m_owner_d) e_dv = 1;
               else           e_iv = 1;
            end
         end
      end

      chk1("i_req_ready", bus.i_req_ready, e_ir);
      chk1("d_req_ready", bus.d_req_ready, e_dr);
      chk1("mem_req_valid", bus.mem_req_valid, e_mv);
      if (e_mv) begin
         chk1("mem_req_write", bus.mem_req_write, e_mw);
         chka("mem_req_addr", bus.mem_req_addr, e_ma);
         chkw("mem_req_wdata", bus.mem_req_wdata, e_md);
      end
      chk1("i_resp_valid", bus.i_resp_valid, e_iv);
      chk1("d_resp_valid", bus.d_resp_valid, e_dv);
      chk1("busy", busy, e_busy);
      chkw("i_resp_data", bus.i_resp_data, m_i_last);
      if (m_d_known) chkw("d_resp_data", bus.d_resp_data, m_d_last);

      acc_i = bus.i_req_valid && bus.i_req_ready;
      acc_d = bus.d_req_valid && bus.d_req_ready;
      if (acc_i) begin
         i_acc_cyc = cyc;
         glog.push_back(1'b0);
      end
      if (acc_d) begin
         d_acc_cyc = cyc;
         glog.push_back(1'b1);
         cap_write = bus.mem_req_write;
         cap_addr  = bus.mem_req_addr;
         cap_wdata = bus.mem_req_wdata;
      end
      if (bus.i_resp_valid) begin
         i_resp_cyc  = cyc;
         i_resp_cnt++;
         i_resp_seen = bus.i_resp_data;
      end
      if (bus.d_resp_valid) begin
         d_resp_cyc = cyc;
         d_resp_cnt++;
      end
      if (busy) begin
         busy_cnt++;
         if (busy_first < 0) busy_first = cyc;
      end

      lat = (lat_fix > 0) ? lat_fix : $urandom_range(1, 4);
      if (reset) begin
         model_clear();
      end else if (!m_busy) begin
         if (e_dr && dv) begin
            m_busy = 1; m_owner_d = 1; m_write = dw;
            m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
            m_cnt = lat - 1;
            m_mem_data = data_fix_en ? data_fix : rand_line();
         end else if (e_ir && iv) begin
            m_busy = 1; m_owner_d = 0; m_write = 0;
            m_streak = 0;
            m_cnt = lat - 1;
            m_mem_data = data_fix_en ? data_fix : rand_line();
         end
      end else if (!m_have) begin
         if (mrv) begin
            m_have = 1;
            if (m_owner_d) begin
               m_d_last  = mrd;
               m_d_known = !m_write;
            end else begin
               m_i_last = mrd;
            end
         end else if (m_cnt > 0) begin
            m_cnt--;
         end
      end else begin
         m_busy = 0;
         m_have = 0;
      end

      @(posedge clk);
      #1;
      cyc++;
      force_resp = 1'b0;

      if (rand_reqs) begin
         if (acc_i || !bus.i_req_valid) begin
            bus.i_req_valid = ($urandom_range(0, 2) == 0);
            bus.i_req_addr  = $urandom() & 32'hFFFF_FFF0;
         end else if ($urandom_range(0, 15) == 0) begin
            bus.i_req_valid = 1'b0;
         end
         if (acc_d || !bus.d_req_valid) begin
            bus.d_req_valid = ($urandom_range(0, 1) == 0);
            bus.d_req_write = ($urandom_range(0, 2) == 0);
            bus.d_req_addr  = $urandom() & 32'hFFFF_FFF0;
            bus.d_req_wdata = rand_line();
         end else if ($urandom_range(0, 15) == 0) begin
            bus.d_req_valid = 1'b0;
         end
      end else if (!sticky) begin
         if (acc_i) bus.i_req_valid = 1'b0;
         if (acc_d) bus.d_req_valid = 1'b0;
      end
   endtask

   initial begin
      int         t0;
      logic [9:0] gbits;

      reset = 1'b1;
      bus.i_req_valid    = 1'b0;
      bus.i_req_addr     = '0;
      bus.d_req_valid    = 1'b0;
      bus.d_req_write    = 1'b0;
      bus.d_req_addr     = '0;
      bus.d_req_wdata    = '0;
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = '0;
      model_clear();
      reset_obs();

      @(posedge clk);
      #1;
      step();
      step();
      reset = 1'b0;
      #1;
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_mem_req_valid", bus.mem_req_valid, 1'b0);
      chkw("rst_i_resp_data", bus.i_resp_data, '0);
      chkw("rst_d_resp_data", bus.d_resp_data, '0);
      step();

      // fetch alone, latency 3
      reset_obs();
      lat_fix = 3; ready_mode = 1; data_fix_en = 1'b1; data_fix = {4{32'hA5A5_A5A5}};
      bus.i_req_valid = 1'b1;
      bus.i_req_addr  = 32'h100;
      t0 = cyc;
      repeat (8) step();
      chki("t1_accept_cycle", i_acc_cyc, t0);
      chki("t1_resp_latency", i_resp_cyc - i_acc_cyc, 4);
      chkw("t1_resp_data", i_resp_seen, {4{32'hA5A5_A5A5}});
      chki("t1_busy_first", busy_first - t0, 1);
      chki("t1_busy_cycles", busy_cnt, 4);
      chki("t1_resp_count", i_resp_cnt, 1);

      // simultaneous requests: data first, fetch right after the data response
      reset_obs();
      data_fix_en = 1'b0;
      bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h200;
      bus.d_req_valid = 1'b1; bus.d_req_write = 1'b0; bus.d_req_addr = 32'h300;
      t0 = cyc;
      repeat (12) step();
      chki("t2_d_first", d_acc_cyc, t0);
      chki("t2_d_resp", d_resp_cyc - d_acc_cyc, 4);
      chki("t2_i_after_d", i_acc_cyc - d_acc_cyc, 5);
      chki("t2_i_resp", i_resp_cyc - i_acc_cyc, 4);

      // both held: streak limit forces a fetch grant every fifth grant
      reset = 1'b1;
      step();
      reset = 1'b0;
      lat_fix = 1; sticky = 1'b1;
      glog.delete();
      bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h500;
      bus.d_req_valid = 1'b1; bus.d_req_write = 1'b0; bus.d_req_addr = 32'h600;
      repeat (32) step();
      sticky = 1'b0;
      bus.i_req_valid = 1'b0;
      bus.d_req_valid = 1'b0;
      gbits = '0;
      for (int k = 0; k < 10; k++) begin
         gbits = {gbits[8:0], (k < glog.size()) ? glog[k] : 1'b0};
      end
      chki("t3_grant_count", (glog.size() >= 10) ? 1 : 0, 1);
      chki("t3_grant_seq", int'(gbits), 'h3DE);
      repeat (4) step();

      // memory not ready for five cycles
      reset_obs();
      lat_fix = 2; ready_mode = 0;
      bus.d_req_valid = 1'b1; bus.d_req_write = 1'b0; bus.d_req_addr = 32'h480;
      bus.d_req_wdata = rand_line();
      t0 = cyc;
      repeat (5) step();
      chki("t4_no_accept", d_acc_cyc, -1);
      chki("t4_stays_idle", busy_cnt, 0);
      ready_mode = 1;
      step();
      chki("t4_accept_cycle", d_acc_cyc - t0, 5);
      repeat (6) step();

      // writeback
      reset_obs();
      bus.d_req_valid = 1'b1; bus.d_req_write = 1'b1; bus.d_req_addr = 32'h40;
      bus.d_req_wdata = {4{32'hDEAD_BEEF}};
      repeat (8) step();
      chk1("t5_mem_write", cap_write, 1'b1);
      chka("t5_mem_addr", cap_addr, 32'h40);
      chkw("t5_mem_wdata", cap_wdata, {4{32'hDEAD_BEEF}});
      chki("t5_d_resp_count", d_resp_cnt, 1);
      chki("t5_i_resp_count", i_resp_cnt, 0);

      // saturate the streak, then reset mid-transaction and inject a stale response
      lat_fix = 3;
      bus.d_req_write = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus.d_req_valid = 1'b1;
         bus.d_req_addr  = 32'h1000 + 32'(k * 16);
         repeat (6) step();
      end
      lat_fix = 4;
      bus.d_req_valid = 1'b1;
      bus.d_req_addr  = 32'h2000;
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      reset_obs();
      step();
      force_resp = 1'b1;
      step();
      repeat (2) step();
      chki("t6_no_resp_pulse", i_resp_cnt + d_resp_cnt, 0);
      chki("t6_not_busy", busy_cnt, 0);
      glog.delete();
      lat_fix = 3;
      bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h3000;
      bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h4000;
      repeat (14) step();
      chk1("t6_first_grant_d", (glog.size() > 0) ? glog[0] : 1'b0, 1'b1);
      chki("t6_i_after_d", i_acc_cyc - d_acc_cyc, 5);
      chki("t6_i_resp_latency", i_resp_cyc - i_acc_cyc, 4);

      // randomized traffic with random latency, back-pressure, spurious responses, resets
      ready_mode = -1; lat_fix = 0; spur_en = 1'b1; rand_reqs = 1'b1;
      for (int n = 0; n < 4000; n++) begin
         reset = ($urandom_range(0, 299) == 0);
         step();
      end
      reset = 1'b0; rand_reqs = 1'b0; spur_en = 1'b0;
      bus.i_req_valid = 1'b0;
      bus.d_req_valid = 1'b0;
      repeat (8) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
